// File: rtl/bus_seven_seg_scan_pkg.sv
// Shared constants for the bus-mapped seven-segment scanner: register map,
// CTRL field layout and the blank-display patterns.
package bus_seven_seg_scan_pkg;

  typedef enum logic [2:0] {
    REG_PAIR0 = 3'd0,
    REG_PAIR1 = 3'd1,
    REG_PAIR2 = 3'd2,
    REG_PAIR3 = 3'd3,
    REG_DP    = 3'd4,
    REG_CTRL  = 3'd5
  } reg_sel_e;

  localparam logic [7:0] DIGIT_PAIR_0 = 8'd0;
  localparam logic [7:0] DIGIT_PAIR_1 = 8'd1;
  localparam logic [7:0] DIGIT_PAIR_2 = 8'd2;
  localparam logic [7:0] DIGIT_PAIR_3 = 8'd3;
  localparam logic [7:0] DP_MASK      = 8'd4;
  localparam logic [7:0] CTRL         = 8'd5;
  localparam logic [7:0] NUM_REGS     = 8'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_BRIGHT_W   = 4;

  localparam logic [7:0] CTRL_RESET = 8'hF1;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

endpackage

// File: rtl/bus_seven_seg_scan_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder (bit0 = a).
module hex_to_seg7 (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segN
);

  // Lowercase glyphs for b and d keep them distinct from 8 and 0.
  always_comb begin
    o_segN = 7'h7F;
    case (i_nibble)
      4'h0: o_segN = 7'h40;
      4'h1: o_segN = 7'h79;
      4'h2: o_segN = 7'h24;
      4'h3: o_segN = 7'h30;
      4'h4: o_segN = 7'h19;
      4'h5: o_segN = 7'h12;
      4'h6: o_segN = 7'h02;
      4'h7: o_segN = 7'h78;
      4'h8: o_segN = 7'h00;
      4'h9: o_segN = 7'h10;
      4'hA: o_segN = 7'h08;
      4'hB: o_segN = 7'h03;
      4'hC: o_segN = 7'h46;
      4'hD: o_segN = 7'h21;
      4'hE: o_segN = 7'h06;
      4'hF: o_segN = 7'h0E;
      default: o_segN = 7'h7F;
    endcase
  end

endmodule

// File: rtl/bus_seven_seg_scan.sv
// Bus-mapped multi-digit seven-segment controller: register file, bus decode,
// digit scan with per-slot brightness PWM and registered active-low outputs.
module bus_seven_seg_scan
  import bus_seven_seg_scan_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hD0,
  parameter int         NUM_DIGITS = 4,
  parameter int         SUB_DIV    = 3125
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUS_WE,
  input  logic                  BUS_RE,
  input  logic [7:0]            ADDR,
  input  logic [7:0]            DATA_IN,
  output logic [7:0]            DATA_OUT,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] DIGIT_SEL
);

  localparam int PRESC_W = (SUB_DIV > 2) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]            r_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_dpMask;
  logic                  r_enable;
  logic [3:0]            r_bright;
  logic [7:0]            r_dataOut;

  logic [PRESC_W-1:0]    r_presc;
  logic [3:0]            r_subPhase;
  logic [IDX_W-1:0]      r_digitIdx;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_digitSel;

  logic [7:0]            w_offset;
  logic                  w_hit;
  reg_sel_e              w_regSel;
  logic [7:0]            w_readVal;
  logic [3:0]            w_nibble;
  logic                  w_dpBit;
  logic                  w_on;
  logic [6:0]            w_segDecoded;
  logic [NUM_DIGITS-1:0] w_digitSel;

  assign w_offset = ADDR - BASE_ADDR;
  assign w_hit    = (ADDR >= BASE_ADDR) && (w_offset < NUM_REGS);
  assign w_regSel = reg_sel_e'(w_offset[2:0]);

  // Register file; nibbles and DP bits beyond NUM_DIGITS simply have no storage.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'h0;
      r_dpMask <= '0;
      r_enable <= CTRL_RESET[CTRL_EN_BIT];
      r_bright <= CTRL_RESET[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
    end else if (BUS_WE && w_hit) begin
      case (w_regSel)
        REG_PAIR0, REG_PAIR1, REG_PAIR2, REG_PAIR3: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_offset[2:0] == 3'(i / 2))
              r_digit[i] <= (i % 2 == 1) ? DATA_IN[7:4] : DATA_IN[3:0];
          end
        end
        REG_DP: r_dpMask <= DATA_IN[NUM_DIGITS-1:0];
        REG_CTRL: begin
          r_enable <= DATA_IN[CTRL_EN_BIT];
          r_bright <= DATA_IN[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_readVal = '0;
    case (w_regSel)
      REG_PAIR0, REG_PAIR1, REG_PAIR2, REG_PAIR3: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_offset[2:0] == 3'(i / 2))
            w_readVal[(i % 2) * 4 +: 4] = r_digit[i];
        end
      end
      REG_DP:   w_readVal[NUM_DIGITS-1:0] = r_dpMask;
      REG_CTRL: w_readVal = {r_bright, 3'b000, r_enable};
      default:  w_readVal = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_dataOut <= 8'h00;
    else        r_dataOut <= (BUS_RE && w_hit) ? w_readVal : 8'h00;
  end

  // Disabling holds every counter at zero so re-enabling restarts at digit 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_presc    <= '0;
      r_subPhase <= 4'h0;
      r_digitIdx <= '0;
    end else if (!r_enable) begin
      r_presc    <= '0;
      r_subPhase <= 4'h0;
      r_digitIdx <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc    <= '0;
      r_subPhase <= r_subPhase + 4'd1;
      if (r_subPhase == 4'hF)
        r_digitIdx <= (r_digitIdx == IDX_MAX) ? '0 : r_digitIdx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_comb begin
    w_nibble   = 4'h0;
    w_dpBit    = 1'b0;
    w_on       = r_enable && (r_subPhase <= r_bright);
    w_digitSel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digitIdx == IDX_W'(i)) begin
        w_nibble      = r_digit[i];
        w_dpBit       = r_dpMask[i];
        w_digitSel[i] = !w_on;
      end
    end
  end

  hex_to_seg7 u_hexToSeg7 (
    .i_nibble (w_nibble),
    .o_segN   (w_segDecoded)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_seg      <= SEG_OFF;
      r_dp       <= 1'b1;
      r_digitSel <= '1;
    end else begin
      r_seg      <= w_on ? w_segDecoded : SEG_OFF;
      r_dp       <= w_on ? ~w_dpBit : 1'b1;
      r_digitSel <= w_digitSel;
    end
  end

  assign DATA_OUT  = r_dataOut;
  assign SEG       = r_seg;
  assign DP        = r_dp;
  assign DIGIT_SEL = r_digitSel;

endmodule

// File: tb/tb_bus_seven_seg_scan.sv
// Directed bench for bus_seven_seg_scan: a 4-digit and a 3-digit instance share
// one bus; expected values are hand-computed for SUB_DIV=2 (32-cycle slots).
module tb_bus_seven_seg_scan;

  localparam logic [7:0] BASE = 8'hD0;

  logic       clk;
  logic       resetN;
  logic       busWe;
  logic       busRe;
  logic [7:0] addr;
  logic [7:0] dataIn;

  logic [7:0] dataOut4;
  logic [6:0] seg4;
  logic       dp4;
  logic [3:0] digitSel4;

  logic [7:0] dataOut3;
  logic [6:0] seg3;
  logic       dp3;
  logic [2:0] digitSel3;

  int checkCount = 0;
  int failCount  = 0;
  int onCount;

  bus_seven_seg_scan #(.BASE_ADDR(BASE), .NUM_DIGITS(4), .SUB_DIV(2)) dut4 (
    .CLK(clk), .RESET(resetN), .BUS_WE(busWe), .BUS_RE(busRe), .ADDR(addr),
    .DATA_IN(dataIn), .DATA_OUT(dataOut4), .SEG(seg4), .DP(dp4), .DIGIT_SEL(digitSel4)
  );

  bus_seven_seg_scan #(.BASE_ADDR(BASE), .NUM_DIGITS(3), .SUB_DIV(2)) dut3 (
    .CLK(clk), .RESET(resetN), .BUS_WE(busWe), .BUS_RE(busRe), .ADDR(addr),
    .DATA_IN(dataIn), .DATA_OUT(dataOut3), .SEG(seg3), .DP(dp3), .DIGIT_SEL(digitSel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle for a single clock edge, then return the bus to idle.
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
    busWe  = we;
    busRe  = re;
    addr   = a;
    dataIn = d;
    tick();
    busWe  = 1'b0;
    busRe  = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, BASE + off, d);
  endtask

  task automatic busRead(input logic [7:0] off);
    applyStimulus(1'b0, 1'b1, BASE + off, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetN = 1'b0;
    busWe  = 1'b0;
    busRe  = 1'b0;
    addr   = 8'h00;
    dataIn = 8'h00;
    #12;
    checkOutput("rst_dataout", dataOut4, 8'h00);
    checkOutput("rst_seg", seg4, 7'h7F);
    checkOutput("rst_dp", dp4, 1'b1);
    checkOutput("rst_sel", digitSel4, 4'hF);
    resetN = 1'b1;

    // Default display after reset: all digits "0", full brightness, 32-cycle slots.
    tick();
    checkOutput("scan_d0_seg", seg4, 7'h40);
    checkOutput("scan_d0_sel", digitSel4, 4'b1110);
    checkOutput("scan_d0_dp", dp4, 1'b1);
    repeat (31) tick();
    checkOutput("scan_d0_end", digitSel4, 4'b1110);
    tick();
    checkOutput("scan_d1_start", digitSel4, 4'b1101);
    repeat (95) tick();
    checkOutput("scan_d3_end", digitSel4, 4'b0111);
    tick();
    checkOutput("scan_wrap_d0", digitSel4, 4'b1110);

    busWrite(8'd0, 8'h3A);
    busWrite(8'd1, 8'hF7);
    busRead(8'd1);
    checkOutput("read_pair1", dataOut4, 8'hF7);
    tick();
    checkOutput("read_idle_zero", dataOut4, 8'h00);

    applyStimulus(1'b1, 1'b0, 8'hCF, 8'h12);
    applyStimulus(1'b1, 1'b0, 8'hD6, 8'h77);
    applyStimulus(1'b0, 1'b1, 8'hD6, 8'h00);
    checkOutput("read_miss", dataOut4, 8'h00);
    busRead(8'd0);
    checkOutput("read_pair0_after_miss", dataOut4, 8'h3A);

    busWrite(8'd5, 8'h00);
    tick();
    tick();
    checkOutput("dis_seg", seg4, 7'h7F);
    checkOutput("dis_dp", dp4, 1'b1);
    checkOutput("dis_sel", digitSel4, 4'hF);
    busRead(8'd5);
    checkOutput("read_ctrl_dis", dataOut4, 8'h00);

    busWrite(8'd5, 8'hF1);
    tick();
    checkOutput("en_d0_seg", seg4, 7'h08);
    checkOutput("en_d0_sel", digitSel4, 4'b1110);
    repeat (32) tick();
    checkOutput("en_d1_seg", seg4, 7'h30);
    checkOutput("en_d1_sel", digitSel4, 4'b1101);
    repeat (32) tick();
    checkOutput("en_d2_seg", seg4, 7'h78);
    checkOutput("en_d2_sel", digitSel4, 4'b1011);
    repeat (32) tick();
    checkOutput("en_d3_seg", seg4, 7'h0E);
    checkOutput("en_d3_sel", digitSel4, 4'b0111);

    // Brightness 3: lit for sub-phases 0..3, i.e. 8 of the 32 cycles in a slot.
    busWrite(8'd5, 8'h00);
    busWrite(8'd5, 8'h31);
    onCount = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (digitSel4 != 4'hF) onCount++;
      if (i == 8) checkOutput("pwm_last_on", digitSel4, 4'b1110);
      if (i == 9) checkOutput("pwm_first_off_seg", seg4, 7'h7F);
    end
    checkOutput("pwm_on_cycles", onCount, 8);
    tick();
    checkOutput("pwm_d1_sel", digitSel4, 4'b1101);
    checkOutput("pwm_d1_seg", seg4, 7'h30);

    busWrite(8'd5, 8'hF1);
    applyStimulus(1'b1, 1'b1, BASE + 8'd5, 8'h51);
    checkOutput("rw_same_old", dataOut4, 8'hF1);
    busRead(8'd5);
    checkOutput("rw_same_new", dataOut4, 8'h51);

    busWrite(8'd1, 8'hFF);
    busWrite(8'd4, 8'hFF);
    busRead(8'd1);
    checkOutput("n3_read_pair1", dataOut3, 8'h0F);
    checkOutput("n4_read_pair1", dataOut4, 8'hFF);
    busRead(8'd4);
    checkOutput("n3_read_dp", dataOut3, 8'h07);
    checkOutput("n4_read_dp", dataOut4, 8'h0F);

    busWrite(8'd5, 8'h00);
    busWrite(8'd5, 8'hF1);
    tick();
    checkOutput("n3_d0_sel", digitSel3, 3'b110);
    checkOutput("n3_d0_dp", dp3, 1'b0);
    checkOutput("n3_d0_seg", seg3, 7'h08);
    repeat (32) tick();
    checkOutput("n3_d1_sel", digitSel3, 3'b101);
    checkOutput("n3_d1_dp", dp3, 1'b0);
    repeat (32) tick();
    checkOutput("n3_d2_sel", digitSel3, 3'b011);
    checkOutput("n3_d2_dp", dp3, 1'b0);
    checkOutput("n3_d2_seg", seg3, 7'h0E);
    repeat (32) tick();
    checkOutput("n3_wrap_sel", digitSel3, 3'b110);

    // Reset lands in the middle of a write cycle; nothing of it may stick.
    busWrite(8'd5, 8'h00);
    busWe  = 1'b1;
    addr   = BASE;
    dataIn = 8'h55;
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("rstmid_seg", seg4, 7'h7F);
    checkOutput("rstmid_sel", digitSel4, 4'hF);
    tick();
    busWe  = 1'b0;
    resetN = 1'b1;
    busRead(8'd0);
    checkOutput("rstmid_pair0", dataOut4, 8'h00);
    busRead(8'd4);
    checkOutput("rstmid_dp", dataOut4, 8'h00);
    busRead(8'd5);
    checkOutput("rstmid_ctrl", dataOut4, 8'hF1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
